// File: rtl/if_id_stall_flush_ctrl.sv
// IF/ID pipeline register owner: applies load-use stalls and taken-branch flushes,
// drives PC write / ID-EX bubble, and keeps stall/flush counters plus a stall watchdog.
module if_id_stall_flush_ctrl #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MAX_STALL    = 8,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_use_hz,
  input  logic              branch_taken,
  input  logic [DATA_W-1:0] if_instr,
  input  logic [DATA_W-1:0] if_pc_plus4,
  output logic              pc_write,
  output logic              idex_bubble,
  output logic [DATA_W-1:0] id_instr,
  output logic [DATA_W-1:0] id_pc_plus4,
  output logic              id_valid,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count,
  output logic              stall_timeout
);

  localparam int unsigned FR_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int unsigned SR_W = $clog2(MAX_STALL + 1);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [FR_W-1:0]     flush_rem_q, flush_rem_d;
  logic [SR_W-1:0]     stall_run_q, stall_run_d;
  logic [DATA_W-1:0]   id_instr_q, id_instr_d;
  logic [DATA_W-1:0]   id_pc_q, id_pc_d;
  logic                id_valid_q, id_valid_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;
  logic                timeout_q, timeout_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      flush_rem_q <= '0;
      stall_run_q <= '0;
      id_instr_q  <= '0;
      id_pc_q     <= '0;
      id_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_rem_q <= flush_rem_d;
      stall_run_q <= stall_run_d;
      id_instr_q  <= id_instr_d;
      id_pc_q     <= id_pc_d;
      id_valid_q  <= id_valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // Next-state and Mealy pipeline controls
  always_comb begin
    state_d     = state_q;
    flush_rem_d = flush_rem_q;
    stall_run_d = stall_run_q;
    id_instr_d  = id_instr_q;
    id_pc_d     = id_pc_q;
    id_valid_d  = id_valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    timeout_d   = timeout_q;
    pc_write    = 1'b1;
    idex_bubble = 1'b0;

    unique case (state_q)
      RUN: begin
        if (branch_taken) begin
          id_instr_d  = '0;
          id_pc_d     = '0;
          id_valid_d  = 1'b0;
          stall_run_d = '0;
          if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
          if (FLUSH_CYCLES > 1) begin
            flush_rem_d = FR_W'(FLUSH_CYCLES - 1);
            state_d     = FLUSH;
          end
        end else if (load_use_hz) begin
          pc_write    = 1'b0;
          idex_bubble = 1'b1;
          if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
          if (stall_run_q != SR_W'(MAX_STALL)) stall_run_d = stall_run_q + SR_W'(1);
          if (stall_run_d == SR_W'(MAX_STALL)) timeout_d = 1'b1;
        end else begin
          id_instr_d  = if_instr;
          id_pc_d     = if_pc_plus4;
          id_valid_d  = 1'b1;
          stall_run_d = '0;
        end
      end
      FLUSH: begin
        // ID holds a squashed slot, so hazard requests are meaningless here
        id_instr_d  = '0;
        id_pc_d     = '0;
        id_valid_d  = 1'b0;
        flush_rem_d = flush_rem_q - FR_W'(1);
        if (flush_rem_q == FR_W'(1)) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    if (rst) begin
      pc_write    = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  assign id_instr      = id_instr_q;
  assign id_pc_plus4   = id_pc_q;
  assign id_valid      = id_valid_q;
  assign stall_count   = stall_cnt_q;
  assign flush_count   = flush_cnt_q;
  assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_if_id_stall_flush_ctrl.sv
// Directed-vector bench for if_id_stall_flush_ctrl with FLUSH_CYCLES=3, MAX_STALL=4;
// expected values are queued by the driver and checked by an independent monitor.
module tb_if_id_stall_flush_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_use_hz;
  logic        branch_taken;
  logic [31:0] if_instr;
  logic [31:0] if_pc_plus4;
  logic        pc_write;
  logic        idex_bubble;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic [15:0] stall_count;
  logic [15:0] flush_count;
  logic        stall_timeout;

  int checks = 0;
  int errors = 0;
  int vec_no = 0;

  typedef struct {
    int          idx;
    logic        pcw;
    logic        bub;
    logic [31:0] ins;
    logic [31:0] pc;
    logic        vld;
    logic [15:0] sc;
    logic [15:0] fc;
    logic        to;
  } exp_t;

  exp_t exp_q[$];

  if_id_stall_flush_ctrl #(
    .DATA_W      (32),
    .FLUSH_CYCLES(3),
    .MAX_STALL   (4),
    .CNT_W       (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load_use_hz  (load_use_hz),
    .branch_taken (branch_taken),
    .if_instr     (if_instr),
    .if_pc_plus4  (if_pc_plus4),
    .pc_write     (pc_write),
    .idex_bubble  (idex_bubble),
    .id_instr     (id_instr),
    .id_pc_plus4  (id_pc_plus4),
    .id_valid     (id_valid),
    .stall_count  (stall_count),
    .flush_count  (flush_count),
    .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the expected pre-edge controls and post-edge state
  task automatic vec(input logic r, input logic lu, input logic bt,
                     input logic [31:0] ins_i, input logic [31:0] pc_i,
                     input logic e_pcw, input logic e_bub,
                     input logic [31:0] e_ins, input logic [31:0] e_pc, input logic e_vld,
                     input logic [15:0] e_sc, input logic [15:0] e_fc, input logic e_to);
    exp_t e;
    @(negedge clk);
    rst          = r;
    load_use_hz  = lu;
    branch_taken = bt;
    if_instr     = ins_i;
    if_pc_plus4  = pc_i;
    e.idx = vec_no; e.pcw = e_pcw; e.bub = e_bub; e.ins = e_ins; e.pc = e_pc;
    e.vld = e_vld; e.sc = e_sc; e.fc = e_fc; e.to = e_to;
    exp_q.push_back(e);
    vec_no++;
  endtask

  // Monitor: controls sampled mid-low-phase, registers sampled just after the edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_write",    e.idx, 32'(pc_write),    32'(e.pcw));
        chk("idex_bubble", e.idx, 32'(idex_bubble), 32'(e.bub));
        @(posedge clk);
        #1;
        chk("id_instr",      e.idx, id_instr,              e.ins);
        chk("id_pc_plus4",   e.idx, id_pc_plus4,           e.pc);
        chk("id_valid",      e.idx, 32'(id_valid),         32'(e.vld));
        chk("stall_count",   e.idx, 32'(stall_count),      32'(e.sc));
        chk("flush_count",   e.idx, 32'(flush_count),      32'(e.fc));
        chk("stall_timeout", e.idx, 32'(stall_timeout),    32'(e.to));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; load_use_hz = 1'b0; branch_taken = 1'b0;
    if_instr = '0; if_pc_plus4 = '0;
    //  rst lu bt  instr         pc+4        pcw bub id_instr      id_pc       vld sc   fc   to
    vec(1, 0, 0, 32'h0,        32'h0,        0, 1, 32'h0,        32'h0,        0, 16'd0, 16'd0, 0);
    vec(1, 0, 0, 32'h0,        32'h0,        0, 1, 32'h0,        32'h0,        0, 16'd0, 16'd0, 0);
    // clean fetches
    vec(0, 0, 0, 32'h8C010004, 32'h4,        1, 0, 32'h8C010004, 32'h4,        1, 16'd0, 16'd0, 0);
    vec(0, 0, 0, 32'h00221820, 32'h8,        1, 0, 32'h00221820, 32'h8,        1, 16'd0, 16'd0, 0);
    vec(0, 0, 0, 32'h00000000, 32'hC,        1, 0, 32'h00000000, 32'hC,        1, 16'd0, 16'd0, 0);
    // single load-use stall holds IF/ID
    vec(0, 0, 0, 32'h00221820, 32'h10,       1, 0, 32'h00221820, 32'h10,       1, 16'd0, 16'd0, 0);
    vec(0, 1, 0, 32'h00430820, 32'h14,       0, 1, 32'h00221820, 32'h10,       1, 16'd1, 16'd0, 0);
    vec(0, 0, 0, 32'h00430820, 32'h14,       1, 0, 32'h00430820, 32'h14,       1, 16'd1, 16'd0, 0);
    // taken branch: three flushed slots, requests during FLUSH ignored
    vec(0, 0, 1, 32'hAAAA0001, 32'h18,       1, 0, 32'h0,        32'h0,        0, 16'd1, 16'd1, 0);
    vec(0, 1, 1, 32'hAAAA0002, 32'h1C,       1, 0, 32'h0,        32'h0,        0, 16'd1, 16'd1, 0);
    vec(0, 1, 0, 32'hAAAA0003, 32'h20,       1, 0, 32'h0,        32'h0,        0, 16'd1, 16'd1, 0);
    vec(0, 0, 0, 32'h01000000, 32'h24,       1, 0, 32'h01000000, 32'h24,       1, 16'd1, 16'd1, 0);
    // branch and load-use together: flush wins
    vec(0, 1, 1, 32'h02000000, 32'h28,       1, 0, 32'h0,        32'h0,        0, 16'd1, 16'd2, 0);
    vec(0, 0, 0, 32'h03000000, 32'h2C,       1, 0, 32'h0,        32'h0,        0, 16'd1, 16'd2, 0);
    vec(0, 0, 0, 32'h04000000, 32'h30,       1, 0, 32'h0,        32'h0,        0, 16'd1, 16'd2, 0);
    vec(0, 0, 0, 32'h05000000, 32'h34,       1, 0, 32'h05000000, 32'h34,       1, 16'd1, 16'd2, 0);
    // reset, then stall watchdog at 4 consecutive stalls
    vec(1, 0, 0, 32'h05000000, 32'h34,       0, 1, 32'h0,        32'h0,        0, 16'd0, 16'd0, 0);
    vec(0, 0, 0, 32'h05000000, 32'h34,       1, 0, 32'h05000000, 32'h34,       1, 16'd0, 16'd0, 0);
    vec(0, 1, 0, 32'h06000000, 32'h38,       0, 1, 32'h05000000, 32'h34,       1, 16'd1, 16'd0, 0);
    vec(0, 1, 0, 32'h06000000, 32'h38,       0, 1, 32'h05000000, 32'h34,       1, 16'd2, 16'd0, 0);
    vec(0, 1, 0, 32'h06000000, 32'h38,       0, 1, 32'h05000000, 32'h34,       1, 16'd3, 16'd0, 0);
    vec(0, 1, 0, 32'h06000000, 32'h38,       0, 1, 32'h05000000, 32'h34,       1, 16'd4, 16'd0, 1);
    vec(0, 0, 0, 32'h06000000, 32'h38,       1, 0, 32'h06000000, 32'h38,       1, 16'd4, 16'd0, 1);
    vec(0, 1, 0, 32'h07000000, 32'h3C,       0, 1, 32'h06000000, 32'h38,       1, 16'd5, 16'd0, 1);
    vec(0, 0, 0, 32'h07000000, 32'h3C,       1, 0, 32'h07000000, 32'h3C,       1, 16'd5, 16'd0, 1);
    // reset mid-FLUSH (flush_rem=2) with requests asserted
    vec(0, 0, 1, 32'h08000000, 32'h40,       1, 0, 32'h0,        32'h0,        0, 16'd5, 16'd1, 1);
    vec(1, 1, 1, 32'h08000000, 32'h40,       0, 1, 32'h0,        32'h0,        0, 16'd0, 16'd0, 0);
    vec(0, 0, 0, 32'h09000000, 32'h44,       1, 0, 32'h09000000, 32'h44,       1, 16'd0, 16'd0, 0);
    vec(0, 1, 0, 32'h0A000000, 32'h48,       0, 1, 32'h09000000, 32'h44,       1, 16'd1, 16'd0, 0);
    vec(0, 0, 0, 32'h0A000000, 32'h48,       1, 0, 32'h0A000000, 32'h48,       1, 16'd1, 16'd0, 0);

    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
